// File: rtl/instruction_fetch.sv
// instruction_fetch: single-port memory handler that runs fetch, load and store on a shared bus.
// Optional macro INSTR_NOP_RESET_EN resets instruction_o and data_out_INSTR to a NOP.
module instruction_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in_CPU,
    input  logic [31:0] data_in_BUS,
    input  logic        data_en,
    input  logic        bus_full,
    input  logic        memWrite,
    input  logic [31:0] instruction_adr_i,
    output logic [2:0]  state,
    output logic [31:0] address_out,
    output logic [31:0] data_out_CPU,
    output logic [31:0] data_out_BUS,
    output logic [31:0] data_out_INSTR,
    output logic [31:0] instruction_o
);

`ifdef INSTR_NOP_RESET_EN
    localparam logic [31:0] INSTR_RST = 32'h0000_0013;
`else
    localparam logic [31:0] INSTR_RST = 32'h0000_0000;
`endif

    localparam logic [2:0] S_INIT      = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_READ_REQ  = 3'd2;
    localparam logic [2:0] S_WRITE_REQ = 3'd3;
    localparam logic [2:0] S_READ      = 3'd4;
    localparam logic [2:0] S_WRITE     = 3'd5;
    localparam logic [2:0] S_WAIT      = 3'd6;

    logic [2:0]  state_q;
    logic [2:0]  state_d;

    logic        fetch_q;
    logic        fetch_d;
    logic        store_q;
    logic        store_d;
    logic [31:0] addr_d;
    logic [31:0] cpu_d;
    logic [31:0] bus_d;
    logic [31:0] raw_d;
    logic [31:0] instr_d;

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:      state_d = S_IDLE;
            S_IDLE:      state_d = (data_en && memWrite) ? S_WRITE_REQ : S_READ_REQ;
            S_READ_REQ:  state_d = bus_full ? S_READ_REQ : S_READ;
            S_WRITE_REQ: state_d = bus_full ? S_WRITE_REQ : S_WRITE;
            S_READ:      state_d = S_WAIT;
            S_WRITE:     state_d = S_WAIT;
            S_WAIT:      state_d = bus_full ? S_WAIT : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Next register values; everything not touched by the current state holds.
    always_comb begin
        fetch_d = fetch_q;
        store_d = store_q;
        addr_d  = address_out;
        cpu_d   = data_out_CPU;
        bus_d   = data_out_BUS;
        raw_d   = data_out_INSTR;
        instr_d = instruction_o;
        case (state_q)
            S_IDLE: begin
                addr_d = instruction_adr_i;
                unique case (1'b1)
                    !data_en: begin
                        fetch_d = 1'b1;
                        store_d = 1'b0;
                    end
                    data_en && !memWrite: begin
                        fetch_d = 1'b0;
                        store_d = 1'b0;
                    end
                    data_en && memWrite: begin
                        fetch_d = 1'b0;
                        store_d = 1'b1;
                        bus_d   = data_in_CPU;
                    end
                endcase
            end
            S_READ: begin
                if (fetch_q) begin
                    raw_d = data_in_BUS;
                end else begin
                    cpu_d = data_in_BUS;
                end
            end
            S_WAIT: begin
                if (!bus_full && fetch_q) begin
                    instr_d = data_out_INSTR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_q        <= 1'b0;
            store_q        <= 1'b0;
            address_out    <= 32'h0;
            data_out_CPU   <= 32'h0;
            data_out_BUS   <= 32'h0;
            data_out_INSTR <= INSTR_RST;
            instruction_o  <= INSTR_RST;
        end else begin
            fetch_q        <= fetch_d;
            store_q        <= store_d;
            address_out    <= addr_d;
            data_out_CPU   <= cpu_d;
            data_out_BUS   <= bus_d;
            data_out_INSTR <= raw_d;
            instruction_o  <= instr_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized transactions against a transaction-level model.
// Expected states come from each transaction's kind and its chosen stall counts.
module tb_instruction_fetch;

`ifdef INSTR_NOP_RESET_EN
    localparam logic [31:0] INSTR_RST = 32'h0000_0013;
`else
    localparam logic [31:0] INSTR_RST = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in_CPU;
    logic [31:0] data_in_BUS;
    logic        data_en;
    logic        bus_full;
    logic        memWrite;
    logic [31:0] instruction_adr_i;
    logic [2:0]  state;
    logic [31:0] address_out;
    logic [31:0] data_out_CPU;
    logic [31:0] data_out_BUS;
    logic [31:0] data_out_INSTR;
    logic [31:0] instruction_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_addr;
    logic [31:0] m_cpu;
    logic [31:0] m_bus;
    logic [31:0] m_raw;
    logic [31:0] m_instr;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .data_in_CPU       (data_in_CPU),
        .data_in_BUS       (data_in_BUS),
        .data_en           (data_en),
        .bus_full          (bus_full),
        .memWrite          (memWrite),
        .instruction_adr_i (instruction_adr_i),
        .state             (state),
        .address_out       (address_out),
        .data_out_CPU      (data_out_CPU),
        .data_out_BUS      (data_out_BUS),
        .data_out_INSTR    (data_out_INSTR),
        .instruction_o     (instruction_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input logic [2:0] es);
        chk("state", {29'b0, state}, {29'b0, es});
        chk("address_out", address_out, m_addr);
        chk("data_out_CPU", data_out_CPU, m_cpu);
        chk("data_out_BUS", data_out_BUS, m_bus);
        chk("data_out_INSTR", data_out_INSTR, m_raw);
        chk("instruction_o", instruction_o, m_instr);
    endtask

    task automatic model_reset();
        m_addr  = 32'h0;
        m_cpu   = 32'h0;
        m_bus   = 32'h0;
        m_raw   = INSTR_RST;
        m_instr = INSTR_RST;
    endtask

    // Mid-transaction input noise that the block must ignore.
    task automatic scramble();
        data_en           = 1'($urandom);
        memWrite          = 1'($urandom);
        instruction_adr_i = $urandom;
        data_in_CPU       = $urandom;
        data_in_BUS       = $urandom;
    endtask

    // kind: 0 fetch, 1 load, 2 store. Entered and left at a negedge in IDLE.
    task automatic run_txn(input int kind, input logic [31:0] adr,
                           input logic [31:0] cpu, input logic [31:0] bus,
                           input int k1, input int k2, input bit abort);
        data_en           = (kind != 0);
        memWrite          = (kind == 2);
        instruction_adr_i = adr;
        data_in_CPU       = cpu;
        data_in_BUS       = $urandom;
        bus_full          = 1'($urandom);
        @(negedge clk);
        m_addr = adr;
        if (kind == 2) m_bus = cpu;
        for (int i = 0; i <= k1; i++) begin
            chk_all(kind == 2 ? 3'd3 : 3'd2);
            scramble();
            bus_full = (i < k1);
            @(negedge clk);
        end
        chk_all(kind == 2 ? 3'd5 : 3'd4);
        if (abort) return;
        scramble();
        data_in_BUS = bus;
        bus_full    = 1'($urandom);
        @(negedge clk);
        if (kind == 0) m_raw = bus;
        if (kind == 1) m_cpu = bus;
        for (int i = 0; i <= k2; i++) begin
            chk_all(3'd6);
            scramble();
            bus_full = (i < k2);
            @(negedge clk);
        end
        if (kind == 0) m_instr = m_raw;
        chk_all(3'd1);
    endtask

    initial begin
        rst               = 1'b1;
        bus_full          = 1'b1;
        data_en           = 1'b1;
        memWrite          = 1'b1;
        data_in_CPU       = 32'h12345678;
        data_in_BUS       = 32'h12345678;
        instruction_adr_i = 32'h12345678;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_all(3'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk_all(3'd1);

        run_txn(0, 32'h12345678, 32'h0, 32'hABCDEF12, 0, 0, 1'b0);
        chk("lit_fetch_addr", address_out, 32'h12345678);
        chk("lit_fetch_raw", data_out_INSTR, 32'hABCDEF12);
        chk("lit_fetch_instr", instruction_o, 32'hABCDEF12);

        run_txn(0, 32'h12345678, 32'h0, 32'hABCDEF12, 3, 3, 1'b0);

        run_txn(1, 32'h00000100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
        chk("lit_load_cpu", data_out_CPU, 32'hDEADBEEF);
        chk("lit_load_instr", instruction_o, 32'hABCDEF12);

        run_txn(2, 32'h00000200, 32'hCAFEF00D, 32'h0, 1, 2, 1'b0);
        chk("lit_store_bus", data_out_BUS, 32'hCAFEF00D);
        chk("lit_store_addr", address_out, 32'h00000200);

        for (int n = 0; n < 300; n++) begin
            run_txn(int'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Abandon a fetch while in Read.
        run_txn(0, 32'h0000_0040, 32'h0, 32'h1111_2222, 1, 0, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        chk_all(3'd0);
        chk("lit_reset_instr", instruction_o, INSTR_RST);
        @(negedge clk);
        chk_all(3'd0);
        rst = 1'b0;
        bus_full = 1'b1;
        @(negedge clk);
        chk_all(3'd1);
        run_txn(0, 32'h0000_0044, 32'h0, 32'h3333_4444, 0, 1, 1'b0);
        chk("lit_after_reset", instruction_o, 32'h3333_4444);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
